// File: rtl/axitrafficgen_pkg.sv
// Shared definitions for the ESP DMA traffic generator.
// Holds the run mode and FSM state types, the conf_info_reg2 field layout,
// the DMA size-code mapping and a small min helper.
package axitrafficgen_pkg;

  typedef enum logic [1:0] {
    ModeWrite   = 2'd0,
    ModeRead    = 2'd1,
    ModeWrchk   = 2'd2,
    ModeIllegal = 2'd3
  } mode_e;

  // Plain vector type with named constants so the encoding stays fixed.
  typedef logic [2:0] state_e;
  localparam state_e StIdle   = 3'd0;
  localparam state_e StWrReq  = 3'd1;
  localparam state_e StWrData = 3'd2;
  localparam state_e StRdReq  = 3'd3;
  localparam state_e StRdData = 3'd4;
  localparam state_e StDone   = 3'd5;

  // conf_info_reg2 layout
  localparam int unsigned ModeLsb  = 0;
  localparam int unsigned ModeMsb  = 1;
  localparam int unsigned BurstLsb = 8;
  localparam int unsigned BurstMsb = 15;
  localparam int unsigned BaseLsb  = 16;
  localparam int unsigned BaseMsb  = 31;

  function automatic logic [2:0] size_code(input int unsigned data_width);
    return (data_width == 32) ? 3'b010 : 3'b011;
  endfunction

  function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/axitrafficgen_pattern_chk.sv
// Pattern generator and read-back checker.
// pattern    : deterministic beat value for offset i, built from word = base + i
//              ({~word, word} at 64 bits, word at 32 bits).
// chk_valid  : an accepted read beat that must equal pattern.
// clear      : zero the error count; set_sat forces it to all ones (wins).
// err_count  : saturating count of mismatching beats.
module axitrafficgen_pattern_chk #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ERR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  set_sat,
  input  logic [31:0]           base,
  input  logic [31:0]           offset,
  input  logic                  chk_valid,
  input  logic [DATA_WIDTH-1:0] chk_data,
  output logic [DATA_WIDTH-1:0] pattern,
  output logic [ERR_WIDTH-1:0]  err_count
);

  logic [31:0]          word;
  logic [ERR_WIDTH-1:0] err_q, err_d;

  assign word = base + offset;

  if (DATA_WIDTH == 64) begin : g_w64
    assign pattern = {~word, word};
  end else begin : g_w32
    assign pattern = word;
  end

  always_comb begin
    err_d = err_q;
    if (set_sat) begin
      err_d = '1;
    end else if (clear) begin
      err_d = '0;
    end else if (chk_valid && (chk_data != pattern) && !(&err_q)) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;

endmodule

// File: rtl/axitrafficgen_dma_engine.sv
// ESP accelerator DMA traffic generator.
// A rising edge on conf_done starts a run: N beats (conf_info_reg1) are written
// and/or read in bursts of min(burst_m1+1, MAX_BURST) starting at the base index
// (conf_info_reg2). Mode 2 reads the region back and counts pattern mismatches.
// Ports: clk/rst (async active-low), conf_* config, dma_read_* / dma_write_*
// ESP DMA ctrl/chnl handshakes, acc_done completion pulse, debug = {bursts, errors}.
module axitrafficgen_dma_engine
  import axitrafficgen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_BURST  = 256,
  parameter int unsigned ERR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           conf_info_reg1,
  input  logic [31:0]           conf_info_reg2,
  input  logic                  conf_done,
  input  logic                  dma_read_ctrl_ready,
  output logic                  dma_read_ctrl_valid,
  output logic [31:0]           dma_read_ctrl_data_index,
  output logic [31:0]           dma_read_ctrl_data_length,
  output logic [2:0]            dma_read_ctrl_data_size,
  output logic                  dma_read_chnl_ready,
  input  logic                  dma_read_chnl_valid,
  input  logic [DATA_WIDTH-1:0] dma_read_chnl_data,
  input  logic                  dma_write_ctrl_ready,
  output logic                  dma_write_ctrl_valid,
  output logic [31:0]           dma_write_ctrl_data_index,
  output logic [31:0]           dma_write_ctrl_data_length,
  output logic [2:0]            dma_write_ctrl_data_size,
  input  logic                  dma_write_chnl_ready,
  output logic                  dma_write_chnl_valid,
  output logic [DATA_WIDTH-1:0] dma_write_chnl_data,
  output logic                  acc_done,
  output logic [31:0]           debug
);

  localparam logic [2:0]  SizeCode = size_code(DATA_WIDTH);
  localparam logic [31:0] MaxBurst = 32'(MAX_BURST);

  state_e      state_q, state_d;
  mode_e       mode_q, mode_d;
  logic        conf_done_q;
  logic [31:0] n_q, n_d;
  logic [31:0] burst_q, burst_d;
  logic [31:0] base_q, base_d;
  logic [31:0] done_q, done_d;     // beats completed in the current direction
  logic [31:0] left_q, left_d;     // beats left in the current burst
  logic [31:0] index_q, index_d;
  logic [31:0] length_q, length_d;
  logic [2:0]  size_q, size_d;
  logic [15:0] bursts_q, bursts_d;

  logic                  start, clear_err, set_err, chk_valid;
  logic [31:0]           done_inc, cfg_n, cfg_base, cfg_burst;
  mode_e                 cfg_mode;
  logic [DATA_WIDTH-1:0] pattern;
  logic [ERR_WIDTH-1:0]  err_count;
  logic                  unused_cfg;

  assign cfg_n     = conf_info_reg1;
  assign cfg_mode  = mode_e'(conf_info_reg2[ModeMsb:ModeLsb]);
  assign cfg_base  = conf_info_reg2[BaseMsb:BaseLsb] == 16'd0 ? 32'd0
                   : {16'd0, conf_info_reg2[BaseMsb:BaseLsb]};
  assign cfg_burst = min32({24'd0, conf_info_reg2[BurstMsb:BurstLsb]} + 32'd1, MaxBurst);
  assign unused_cfg = ^conf_info_reg2[7:2];

  assign start    = conf_done && !conf_done_q && (state_q == StIdle);
  assign done_inc = done_q + 32'd1;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    n_d       = n_q;
    burst_d   = burst_q;
    base_d    = base_q;
    done_d    = done_q;
    left_d    = left_q;
    index_d   = index_q;
    length_d  = length_q;
    size_d    = size_q;
    bursts_d  = bursts_q;
    clear_err = 1'b0;
    set_err   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          n_d       = cfg_n;
          mode_d    = cfg_mode;
          burst_d   = cfg_burst;
          base_d    = cfg_base;
          done_d    = '0;
          bursts_d  = '0;
          clear_err = 1'b1;
          if (cfg_mode == ModeIllegal) begin
            set_err = 1'b1;
            state_d = StDone;
          end else if (cfg_n == 32'd0) begin
            state_d = StDone;
          end else begin
            index_d  = cfg_base;
            length_d = min32(cfg_burst, cfg_n);
            size_d   = SizeCode;
            state_d  = (cfg_mode == ModeRead) ? StRdReq : StWrReq;
          end
        end
      end
      StWrReq: begin
        if (dma_write_ctrl_ready) begin
          state_d  = StWrData;
          left_d   = length_q;
          bursts_d = bursts_q + 16'd1;
        end
      end
      StWrData: begin
        if (dma_write_chnl_ready) begin
          done_d = done_inc;
          left_d = left_q - 32'd1;
          if (left_q == 32'd1) begin
            if (done_inc == n_q) begin
              if (mode_q == ModeWrchk) begin
                // Read back the same region from its start.
                state_d  = StRdReq;
                done_d   = '0;
                index_d  = base_q;
                length_d = min32(burst_q, n_q);
              end else begin
                state_d = StDone;
              end
            end else begin
              state_d  = StWrReq;
              index_d  = base_q + done_inc;
              length_d = min32(burst_q, n_q - done_inc);
            end
          end
        end
      end
      StRdReq: begin
        if (dma_read_ctrl_ready) begin
          state_d  = StRdData;
          left_d   = length_q;
          bursts_d = bursts_q + 16'd1;
        end
      end
      StRdData: begin
        if (dma_read_chnl_valid) begin
          done_d = done_inc;
          left_d = left_q - 32'd1;
          if (left_q == 32'd1) begin
            if (done_inc == n_q) begin
              state_d = StDone;
            end else begin
              state_d  = StRdReq;
              index_d  = base_q + done_inc;
              length_d = min32(burst_q, n_q - done_inc);
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      mode_q      <= ModeWrite;
      conf_done_q <= 1'b0;
      n_q         <= '0;
      burst_q     <= '0;
      base_q      <= '0;
      done_q      <= '0;
      left_q      <= '0;
      index_q     <= '0;
      length_q    <= '0;
      size_q      <= '0;
      bursts_q    <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      conf_done_q <= conf_done;
      n_q         <= n_d;
      burst_q     <= burst_d;
      base_q      <= base_d;
      done_q      <= done_d;
      left_q      <= left_d;
      index_q     <= index_d;
      length_q    <= length_d;
      size_q      <= size_d;
      bursts_q    <= bursts_d;
    end
  end

  assign chk_valid = (state_q == StRdData) && dma_read_chnl_valid && (mode_q == ModeWrchk);

  axitrafficgen_pattern_chk #(
    .DATA_WIDTH(DATA_WIDTH),
    .ERR_WIDTH (ERR_WIDTH)
  ) u_pattern_chk (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_err),
    .set_sat  (set_err),
    .base     (base_q),
    .offset   (done_q),
    .chk_valid(chk_valid),
    .chk_data (dma_read_chnl_data),
    .pattern  (pattern),
    .err_count(err_count)
  );

  // All handshake outputs decode registered state only; no ready-to-valid path.
  assign dma_write_ctrl_valid       = (state_q == StWrReq);
  assign dma_write_ctrl_data_index  = index_q;
  assign dma_write_ctrl_data_length = length_q;
  assign dma_write_ctrl_data_size   = size_q;
  assign dma_write_chnl_valid       = (state_q == StWrData);
  assign dma_write_chnl_data        = (state_q == StWrData) ? pattern : '0;

  assign dma_read_ctrl_valid        = (state_q == StRdReq);
  assign dma_read_ctrl_data_index   = index_q;
  assign dma_read_ctrl_data_length  = length_q;
  assign dma_read_ctrl_data_size    = size_q;
  assign dma_read_chnl_ready        = (state_q == StRdData);

  assign acc_done = (state_q == StDone);
  assign debug    = {bursts_q, 16'(err_count)};

endmodule

// File: tb/tb_axitrafficgen_dma_engine.sv
module tb_axitrafficgen_dma_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] conf_info_reg1, conf_info_reg2;
  logic        conf_done;
  logic        dma_read_ctrl_ready, dma_read_ctrl_valid;
  logic [31:0] dma_read_ctrl_data_index, dma_read_ctrl_data_length;
  logic [2:0]  dma_read_ctrl_data_size;
  logic        dma_read_chnl_ready, dma_read_chnl_valid;
  logic [63:0] dma_read_chnl_data;
  logic        dma_write_ctrl_ready, dma_write_ctrl_valid;
  logic [31:0] dma_write_ctrl_data_index, dma_write_ctrl_data_length;
  logic [2:0]  dma_write_ctrl_data_size;
  logic        dma_write_chnl_ready, dma_write_chnl_valid;
  logic [63:0] dma_write_chnl_data;
  logic        acc_done;
  logic [31:0] debug;

  always #5 clk = ~clk;

  axitrafficgen_dma_engine dut (
    .clk                       (clk),
    .rst                       (rst),
    .conf_info_reg1            (conf_info_reg1),
    .conf_info_reg2            (conf_info_reg2),
    .conf_done                 (conf_done),
    .dma_read_ctrl_ready       (dma_read_ctrl_ready),
    .dma_read_ctrl_valid       (dma_read_ctrl_valid),
    .dma_read_ctrl_data_index  (dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length (dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size   (dma_read_ctrl_data_size),
    .dma_read_chnl_ready       (dma_read_chnl_ready),
    .dma_read_chnl_valid       (dma_read_chnl_valid),
    .dma_read_chnl_data        (dma_read_chnl_data),
    .dma_write_ctrl_ready      (dma_write_ctrl_ready),
    .dma_write_ctrl_valid      (dma_write_ctrl_valid),
    .dma_write_ctrl_data_index (dma_write_ctrl_data_index),
    .dma_write_ctrl_data_length(dma_write_ctrl_data_length),
    .dma_write_ctrl_data_size  (dma_write_ctrl_data_size),
    .dma_write_chnl_ready      (dma_write_chnl_ready),
    .dma_write_chnl_valid      (dma_write_chnl_valid),
    .dma_write_chnl_data       (dma_write_chnl_data),
    .acc_done                  (acc_done),
    .debug                     (debug)
  );

  int tests = 0;
  int fails = 0;

  // Memory/DMA model state and logs
  logic [63:0] mem [0:1023];
  logic [31:0] wr_idx[$], wr_len[$], rd_idx[$], rd_len[$];
  logic [63:0] wr_data[$];
  logic [31:0] wr_addr, rd_addr, rd_left;
  int          rd_beats, acc_cnt;
  bit          stall, corrupt;
  bit          hold_wc, hold_wd, hold_rc;
  logic [31:0] prev_wc_idx, prev_wc_len, prev_rc_idx, prev_rc_len;
  logic [63:0] prev_wd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_idx.delete(); wr_len.delete(); rd_idx.delete(); rd_len.delete(); wr_data.delete();
    rd_beats = 0;
    acc_cnt  = 0;
  endtask

  function automatic logic [63:0] pat(input logic [31:0] base, input int i);
    logic [31:0] w;
    w = base + 32'(i);
    return {~w, w};
  endfunction

  // DMA responder: decides readies/read data at each falling edge, so every
  // handshake it logs is the one the DUT sees at the following rising edge.
  initial begin
    dma_read_ctrl_ready = 1'b0; dma_read_chnl_valid = 1'b0; dma_read_chnl_data = '0;
    dma_write_ctrl_ready = 1'b0; dma_write_chnl_ready = 1'b0;
    hold_wc = 0; hold_wd = 0; hold_rc = 0; rd_left = 0; wr_addr = 0; rd_addr = 0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        dma_read_ctrl_ready = 1'b0; dma_read_chnl_valid = 1'b0; dma_read_chnl_data = '0;
        dma_write_ctrl_ready = 1'b0; dma_write_chnl_ready = 1'b0;
        hold_wc = 0; hold_wd = 0; hold_rc = 0; rd_left = 0;
      end else begin
        if (acc_done) acc_cnt++;
        // write data channel
        if (hold_wd) begin
          check("wr_chnl_valid_held", dma_write_chnl_valid, 1);
          check("wr_chnl_data_stable", dma_write_chnl_data, prev_wd);
        end
        dma_write_chnl_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (dma_write_chnl_valid && dma_write_chnl_ready) begin
          mem[wr_addr[9:0]] = dma_write_chnl_data;
          wr_data.push_back(dma_write_chnl_data);
          wr_addr = wr_addr + 32'd1;
        end
        hold_wd = dma_write_chnl_valid && !dma_write_chnl_ready;
        prev_wd = dma_write_chnl_data;
        // write ctrl
        if (hold_wc) begin
          check("wr_ctrl_valid_held", dma_write_ctrl_valid, 1);
          check("wr_ctrl_index_stable", dma_write_ctrl_data_index, prev_wc_idx);
          check("wr_ctrl_length_stable", dma_write_ctrl_data_length, prev_wc_len);
        end
        dma_write_ctrl_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (dma_write_ctrl_valid && dma_write_ctrl_ready) begin
          wr_idx.push_back(dma_write_ctrl_data_index);
          wr_len.push_back(dma_write_ctrl_data_length);
          wr_addr = dma_write_ctrl_data_index;
        end
        hold_wc = dma_write_ctrl_valid && !dma_write_ctrl_ready;
        prev_wc_idx = dma_write_ctrl_data_index;
        prev_wc_len = dma_write_ctrl_data_length;
        // read data channel
        if (rd_left != 0 && (!stall || $urandom_range(0, 1) == 1)) begin
          dma_read_chnl_valid = 1'b1;
          dma_read_chnl_data  = mem[rd_addr[9:0]] ^
              ((corrupt && (rd_beats == 3 || rd_beats == 7)) ? 64'h1 : 64'h0);
        end else begin
          dma_read_chnl_valid = 1'b0;
          dma_read_chnl_data  = '0;
        end
        if (dma_read_chnl_valid && dma_read_chnl_ready) begin
          rd_addr = rd_addr + 32'd1;
          rd_left = rd_left - 32'd1;
          rd_beats++;
        end
        // read ctrl
        if (hold_rc) begin
          check("rd_ctrl_valid_held", dma_read_ctrl_valid, 1);
          check("rd_ctrl_index_stable", dma_read_ctrl_data_index, prev_rc_idx);
          check("rd_ctrl_length_stable", dma_read_ctrl_data_length, prev_rc_len);
        end
        dma_read_ctrl_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
          rd_idx.push_back(dma_read_ctrl_data_index);
          rd_len.push_back(dma_read_ctrl_data_length);
          rd_addr = dma_read_ctrl_data_index;
          rd_left = dma_read_ctrl_data_length;
        end
        hold_rc = dma_read_ctrl_valid && !dma_read_ctrl_ready;
        prev_rc_idx = dma_read_ctrl_data_index;
        prev_rc_len = dma_read_ctrl_data_length;
      end
    end
  end

  task automatic run(input string tag, input logic [31:0] n, input logic [1:0] mode,
                     input logic [7:0] bm1, input logic [15:0] base, input bit st, input bit cr);
    int cyc;
    clear_logs();
    stall   = st;
    corrupt = cr;
    conf_info_reg1 = n;
    conf_info_reg2 = {base, bm1, 6'd0, mode};
    conf_done = 1'b1;
    cyc = 0;
    while (acc_cnt == 0 && cyc < 5000) begin
      tick();
      cyc++;
    end
    // Holding conf_done high must not start a second run.
    repeat (4) tick();
    check({tag, "_acc_pulses"}, acc_cnt, 1);
    conf_done = 1'b0;
    tick();
  endtask

  task automatic chk_wr(input string tag, input int k, input logic [31:0] idx,
                        input logic [31:0] len);
    check({tag, "_wr_index"}, wr_idx[k], idx);
    check({tag, "_wr_length"}, wr_len[k], len);
  endtask

  task automatic chk_rd(input string tag, input int k, input logic [31:0] idx,
                        input logic [31:0] len);
    check({tag, "_rd_index"}, rd_idx[k], idx);
    check({tag, "_rd_length"}, rd_len[k], len);
  endtask

  initial begin
    int cyc;
    rst = 1'b0; conf_done = 1'b0; conf_info_reg1 = '0; conf_info_reg2 = '0;
    stall = 0; corrupt = 0;
    #2;
    // Reset state
    check("rst_wr_ctrl_valid", dma_write_ctrl_valid, 0);
    check("rst_rd_ctrl_valid", dma_read_ctrl_valid, 0);
    check("rst_wr_chnl_valid", dma_write_chnl_valid, 0);
    check("rst_rd_chnl_ready", dma_read_chnl_ready, 0);
    check("rst_acc_done", acc_done, 0);
    check("rst_debug", debug, 0);
    check("rst_index_len", {dma_write_ctrl_data_index, dma_write_ctrl_data_length}, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Mode 2, N=16, B=4, base 0x100
    run("t1", 16, 2'd2, 8'd3, 16'h0100, 0, 0);
    check("t1_wr_reqs", wr_idx.size(), 4);
    check("t1_rd_reqs", rd_idx.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk_wr("t1", k, 32'h100 + 32'(4 * k), 4);
      chk_rd("t1", k, 32'h100 + 32'(4 * k), 4);
    end
    check("t1_data0", wr_data[0], 64'hFFFF_FEFF_0000_0100);
    check("t1_data15", wr_data[15], 64'hFFFF_FEF0_0000_010F);
    check("t1_size", dma_write_ctrl_data_size, 3'b011);
    check("t1_debug", debug, 32'h0008_0000);

    // Mode 2, N=10, B=4: lengths 4,4,2
    run("t2", 10, 2'd2, 8'd3, 16'h0200, 0, 0);
    check("t2_wr_reqs", wr_idx.size(), 3);
    check("t2_rd_reqs", rd_idx.size(), 3);
    chk_wr("t2", 0, 32'h200, 4); chk_wr("t2", 1, 32'h204, 4); chk_wr("t2", 2, 32'h208, 2);
    chk_rd("t2", 0, 32'h200, 4); chk_rd("t2", 1, 32'h204, 4); chk_rd("t2", 2, 32'h208, 2);
    check("t2_debug", debug, 32'h0006_0000);

    // Mode 2 with read beats 3 and 7 corrupted
    run("t3", 16, 2'd2, 8'd3, 16'h0100, 0, 1);
    check("t3_rd_beats", rd_beats, 16);
    check("t3_debug", debug, 32'h0008_0002);

    // Mode 0, N=8, B=3, random stalls
    run("t4", 8, 2'd0, 8'd2, 16'h0040, 1, 0);
    check("t4_wr_reqs", wr_idx.size(), 3);
    check("t4_rd_reqs", rd_idx.size(), 0);
    chk_wr("t4", 0, 32'h40, 3); chk_wr("t4", 1, 32'h43, 3); chk_wr("t4", 2, 32'h46, 2);
    check("t4_beats", wr_data.size(), 8);
    for (int k = 0; k < 8; k++) check("t4_data", wr_data[k], pat(32'h40, k));
    check("t4_debug", debug, 32'h0003_0000);

    // B > N: single burst of N
    run("t5", 5, 2'd0, 8'd15, 16'h0010, 0, 0);
    check("t5_wr_reqs", wr_idx.size(), 1);
    chk_wr("t5", 0, 32'h10, 5);
    check("t5_debug", debug, 32'h0001_0000);

    // Mode 1 read-only: consumes corrupted data without counting it
    run("t6", 4, 2'd1, 8'd3, 16'h0100, 1, 1);
    check("t6_wr_reqs", wr_idx.size(), 0);
    check("t6_rd_reqs", rd_idx.size(), 1);
    chk_rd("t6", 0, 32'h100, 4);
    check("t6_rd_beats", rd_beats, 4);
    check("t6_debug", debug, 32'h0001_0000);

    // Mode 3: straight to DONE, one cycle after start
    clear_logs();
    conf_info_reg1 = 8; conf_info_reg2 = {16'h0, 8'd3, 6'd0, 2'd3}; conf_done = 1'b1;
    tick();
    check("m3_acc_done", acc_done, 1);
    check("m3_debug", debug, 32'h0000_FFFF);
    tick();
    check("m3_acc_low", acc_done, 0);
    conf_done = 1'b0;
    tick();
    check("m3_reqs", wr_idx.size() + rd_idx.size(), 0);

    // N=0 mode 0
    clear_logs();
    conf_info_reg1 = 0; conf_info_reg2 = {16'h0, 8'd3, 6'd0, 2'd0}; conf_done = 1'b1;
    tick();
    check("n0_acc_done", acc_done, 1);
    check("n0_debug", debug, 32'h0);
    tick();
    check("n0_acc_low", acc_done, 0);
    conf_done = 1'b0;
    tick();
    check("n0_reqs", wr_idx.size() + rd_idx.size(), 0);

    // Reset in the middle of a write burst
    clear_logs();
    stall = 0; corrupt = 0;
    conf_info_reg1 = 16; conf_info_reg2 = {16'h0300, 8'd7, 6'd0, 2'd0}; conf_done = 1'b1;
    cyc = 0;
    while (wr_data.size() < 3 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("mid_in_wr_data", dma_write_chnl_valid, 1);
    #1 rst = 1'b0;
    #1;
    check("mid_wr_chnl_valid", dma_write_chnl_valid, 0);
    check("mid_wr_chnl_data", dma_write_chnl_data, 0);
    check("mid_ctrl_valids", {dma_write_ctrl_valid, dma_read_ctrl_valid, dma_read_chnl_ready}, 0);
    check("mid_index_len", {dma_write_ctrl_data_index, dma_write_ctrl_data_length}, 0);
    check("mid_acc_debug", {acc_done, debug}, 0);
    conf_done = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    run("t7", 4, 2'd0, 8'd3, 16'h0300, 0, 0);
    check("t7_wr_reqs", wr_idx.size(), 1);
    chk_wr("t7", 0, 32'h300, 4);
    check("t7_data0", wr_data[0], 64'hFFFF_FCFF_0000_0300);
    check("t7_debug", debug, 32'h0001_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axitrafficgen_dma_engine.md
Name: axitrafficgen_dma_engine

Overview:
Parametrised ESP-accelerator DMA traffic generator, the successor to the fixed 64-bit AXI-bridge traffic block. It drives the ESP DMA ctrl/chnl interface directly with configurable data width, burst length, base index and mode. Writes a deterministic pattern, reads it back and counts mismatches. Sits as the accelerator RTL core between the ESP socket config registers and the socket DMA.

Parameters:
DATA_WIDTH, 64, DMA channel width; legal values 32 and 64. Size code = 3'b010 for 32, 3'b011 for 64.
MAX_BURST, 256, upper bound on beats per DMA transaction; power of 2, at most 256.
ERR_WIDTH, 16, width of the saturating mismatch counter.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-low reset.
conf_info_reg1  in  32  total beats N.
conf_info_reg2  in  32  [1:0] mode, [15:8] burst_m1, [31:16] base index.
conf_done  in  1  level; rising edge starts a run.
dma_read_ctrl_ready  in  1  read ctrl handshake.
dma_read_ctrl_valid  out  1  read request valid.
dma_read_ctrl_data_index  out  32  read start index, in beats.
dma_read_ctrl_data_length  out  32  read beats.
dma_read_ctrl_data_size  out  3  size code.
dma_read_chnl_ready  out  1  read data accept.
dma_read_chnl_valid  in  1  read data valid.
dma_read_chnl_data  in  DATA_WIDTH  read data.
dma_write_ctrl_ready  in  1  write ctrl handshake.
dma_write_ctrl_valid  out  1  write request valid.
dma_write_ctrl_data_index  out  32  write start index.
dma_write_ctrl_data_length  out  32  write beats.
dma_write_ctrl_data_size  out  3  size code.
dma_write_chnl_ready  in  1  write data accept.
dma_write_chnl_valid  out  1  write data valid.
dma_write_chnl_data  out  DATA_WIDTH  write data.
acc_done  out  1  one-cycle completion pulse.
debug  out  32  [15:0] mismatch count, saturating; [31:16] bursts issued, low 16 bits, wrapping.

Behaviour:
- Reset (rst=0, asynchronous): all valids, ready, acc_done = 0; index, length, data = 0; counters = 0; FSM = IDLE. A reset mid-run abandons all outstanding DMA traffic.
- On the first clk edge with conf_done=1 and the previous conf_done=0: latch N, mode, burst B = min(burst_m1+1, MAX_BURST), and base. Clear both counters.
- Modes: 0 write-only; 1 read-only; 2 write then read-check of the same region; 3 illegal, goes straight to DONE and sets debug[15:0]=16'hFFFF.
- FSM states: IDLE, WR_REQ, WR_DATA, RD_REQ, RD_DATA, DONE.
- Transitions:
  - IDLE goes to WR_REQ (modes 0, 2) or RD_REQ (mode 1).
  - A request state goes to its data state on a ctrl handshake (valid & ready).
  - A data state returns to its request state when the burst completes and beats remain.
  - When the final burst completes: WR_DATA goes to RD_REQ in mode 2, otherwise to DONE; RD_DATA goes to DONE.
- Requests: index = base + beats_done; length = min(B, N - beats_done); size per DATA_WIDTH. Fields are registered and stable while valid=1. Valid holds until ready, with no combinational ready-to-valid path. Each accepted request increments the burst count.
- Write data:
  - Beat at global offset i carries pattern(i) = {~(base+i), (base+i)}, each half 32 bits; for DATA_WIDTH=32 it is (base+i).
  - Valid is held and data stable until ready.
  - Back-to-back beats are allowed, giving 1 beat/cycle at full throughput.
- Read data:
  - dma_read_chnl_ready = 1 only in RD_DATA.
  - In mode 2, each accepted beat is compared with pattern(i); a mismatch increments the error count, saturating at all-ones.
  - Modes 1 and 2 both consume data; mode 1 performs no check.
- DONE: acc_done=1 for exactly one cycle, then IDLE. debug holds its value until the next start. A new start requires conf_done to fall and rise again.
- N=0: go straight to DONE, issuing no requests.
- B > N: a single burst of length N.
- Arithmetic: 32-bit, with index wrap-around modulo 2^32 permitted.

Decomposition:
- Shared package axitrafficgen_pkg holds:
  - mode_e (WRITE, READ, WRCHK, ILLEGAL);
  - state_e;
  - the SIZE_CODE function of DATA_WIDTH;
  - the conf_info_reg2 field offsets.
- Sub-module axitrafficgen_pattern_chk: pattern generator plus comparator and saturating error counter, inputs base/offset/beat-valid.

Test Plan:
- Mode 2, N=16, burst_m1=3, base=0x100, zero-latency DMA -> 4 write and 4 read requests with index 0x100,0x104,0x108,0x10C and length 4; debug=0x0008_0000; one acc_done pulse.
- Mode 2, N=10, burst_m1=3 -> lengths 4,4,2 for each direction; debug[31:16]=6.
- Mode 2 with memory model corrupting read beats 3 and 7 -> debug[15:0]=2; all 16 beats accepted.
- Mode 0, N=8, random ready stalls on ctrl/chnl -> data and index stable during stall; data sequence pattern(0..7); no reads issued.
- Reset asserted in WR_DATA mid-burst -> all outputs 0 immediately; a new conf_done edge restarts cleanly from offset 0.
- Mode 3, or N=0 with mode 0 -> no requests; acc_done one cycle after start; debug[15:0]=0xFFFF for mode 3 and 0 for N=0.
